// File: rtl/i2s_pkg.sv
// Shared constants and parameter legality checks for the I2S/TDM receiver.
// Ports: none (package).
package i2s_pkg;

  localparam int DEF_SLOT_BITS   = 32;
  localparam int DEF_SAMPLE_BITS = 24;
  localparam int DEF_CHANNELS    = 2;
  localparam int DEF_FIFO_DEPTH  = 4;

  function automatic bit slot_bits_ok(input int slot_bits);
    return (slot_bits >= 16) && (slot_bits <= 32);
  endfunction

  function automatic bit sample_bits_ok(input int sample_bits, input int slot_bits);
    return (sample_bits >= 8) && (sample_bits <= slot_bits);
  endfunction

  function automatic bit channels_ok(input int channels);
    return (channels == 2) || (channels == 4) || (channels == 8);
  endfunction

  function automatic bit fifo_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous sample FIFO with a valid/ready read side.
// Ports:
//   clk_in, rstn          clock, async active-low reset
//   push, push_data       write request and entry (written only if space or same-cycle pop)
//   full                  all DEPTH entries occupied
//   m_valid, m_ready      read handshake; an entry is popped when both are high
//   m_data                head entry (zero while empty)
module i2s_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop;
  logic             wr_en;

  assign m_valid = (cnt_q != '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en   = push & (~full | pop);
  assign m_data  = m_valid ? mem_q[rd_q] : '0;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (wr_en) wr_d = wr_q + AW'(1);
    if (pop)   rd_d = rd_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; m_data is gated by m_valid so stale words never show.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/i2s_rx_tdm.sv
// I2S / TDM serial audio receiver (bit-clock master for word select).
// Deserialises SLOT_BITS-wide slots, keeps the top SAMPLE_BITS of each and
// queues {sample, slot} in a small FIFO read through a valid/ready port.
// Optional feature macro: I2S_RX_STATS_EN adds the drop_count output.
// Ports:
//   clk_in, rstn           bit clock, async active-low reset
//   enable                 run receiver; low holds the frame at its start
//   i2s_mclk               copy of clk_in
//   i2s_ws                 word select (2 ch) or one-bit frame sync (4/8 ch)
//   i2s_sd                 serial data, MSB first, one-bit delay
//   m_data, m_chan         sample and its slot index
//   m_valid, m_ready       output handshake
//   overflow, clr_ovf      sticky drop flag and its clear
//   drop_count             (I2S_RX_STATS_EN only) saturating drop counter
module i2s_rx_tdm
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                        clk_in,
  input  logic                        rstn,
  input  logic                        enable,
  output logic                        i2s_mclk,
  output logic                        i2s_ws,
  input  logic                        i2s_sd,
  output logic [SAMPLE_BITS-1:0]      m_data,
  output logic [$clog2(CHANNELS)-1:0] m_chan,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        overflow,
  input  logic                        clr_ovf
`ifdef I2S_RX_STATS_EN
  ,output logic [15:0]                drop_count
`endif
);

  localparam int CHAN_W  = $clog2(CHANNELS);
  localparam int POS_W   = $clog2(SLOT_BITS);
  localparam int ENTRY_W = SAMPLE_BITS + CHAN_W;

  if (!slot_bits_ok(SLOT_BITS)) begin : g_bad_slot_bits
    $error("i2s_rx_tdm: SLOT_BITS must be 16..32");
  end
  if (!sample_bits_ok(SAMPLE_BITS, SLOT_BITS)) begin : g_bad_sample_bits
    $error("i2s_rx_tdm: SAMPLE_BITS must be 8..SLOT_BITS");
  end
  if (!channels_ok(CHANNELS)) begin : g_bad_channels
    $error("i2s_rx_tdm: CHANNELS must be 2, 4 or 8");
  end
  if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("i2s_rx_tdm: FIFO_DEPTH must be a power of 2, >= 2");
  end

  // Frame count c is held as (slot_q, pos_q): c = slot_q*SLOT_BITS + pos_q.
  // CHANNELS is a power of two, so slot_q wraps on its own.
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [CHAN_W-1:0]    slot_q, slot_d;
  logic [SLOT_BITS-2:0] sr_q, sr_d;
  logic                 first_q, first_d;
  logic                 overflow_q, overflow_d;

  logic [SLOT_BITS-1:0] slot_word;
  logic [CHAN_W-1:0]    done_slot;
  logic                 push;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   fifo_data;
  logic                 fifo_full;
  logic                 drop;
  logic                 ws_raw;

  // The bit arriving on this edge closes the slot when pos_q wraps to 0, so
  // the full slot word is the shift register plus the live input bit.
  assign slot_word = {sr_q, i2s_sd};
  assign done_slot = slot_q - CHAN_W'(1);
  assign push_data = {slot_word[SLOT_BITS-1 -: SAMPLE_BITS], done_slot};

  always_comb begin
    pos_d   = pos_q;
    slot_d  = slot_q;
    sr_d    = sr_q;
    first_d = first_q;
    push    = 1'b0;
    if (!enable) begin
      pos_d   = '0;
      slot_d  = '0;
      sr_d    = '0;
      first_d = 1'b1;
    end else begin
      sr_d = slot_word[SLOT_BITS-2:0];
      if (pos_q == POS_W'(SLOT_BITS - 1)) begin
        pos_d  = '0;
        slot_d = slot_q + CHAN_W'(1);
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
      if (pos_q == '0) begin
        // The first c==0 edge after start closes a slot that was never fully heard.
        push = !(first_q && (slot_q == '0));
        if (slot_q == '0) first_d = 1'b0;
      end
    end
  end

  always_comb begin
    ws_raw = 1'b0;
    if (CHANNELS == 2) ws_raw = (slot_q != '0);
    else               ws_raw = (slot_q == CHAN_W'(CHANNELS - 1)) &&
                                (pos_q == POS_W'(SLOT_BITS - 1));
  end

  assign i2s_ws   = enable & ws_raw;
  assign i2s_mclk = clk_in;

  assign drop = push & fifo_full & ~(m_valid & m_ready);

  always_comb begin
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      pos_q      <= '0;
      slot_q     <= '0;
      sr_q       <= '0;
      first_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      slot_q     <= slot_d;
      sr_q       <= sr_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  i2s_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (fifo_data)
  );

  assign m_data = fifo_data[ENTRY_W-1 -: SAMPLE_BITS];
  assign m_chan = fifo_data[CHAN_W-1:0];

`ifdef I2S_RX_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop) begin
      if (clr_ovf)                     drop_count_d = 16'd1;
      else if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end else if (clr_ovf) begin
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) drop_count_q <= '0;
    else       drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_i2s_rx_tdm.sv
module tb_i2s_rx_tdm;

  localparam int SB_P[2]  = '{32, 16};
  localparam int SMP_P[2] = '{24, 16};
  localparam int CH_P[2]  = '{2, 8};
  localparam int DEP_P[2] = '{4, 4};

  logic clk_in = 1'b0;
  logic rstn   = 1'b0;
  logic en[2], rdy[2], clr[2], sd[2];

  logic        mclk0, ws0, m_valid0, ovf0;
  logic [23:0] m_data0;
  logic [0:0]  m_chan0;
  logic        mclk1, ws1, m_valid1, ovf1;
  logic [15:0] m_data1;
  logic [2:0]  m_chan1;
`ifdef I2S_RX_STATS_EN
  logic [15:0] dc0, dc1;
`endif

  always #5 clk_in = ~clk_in;

  i2s_rx_tdm u_dut0 (
    .clk_in   (clk_in),
    .rstn     (rstn),
    .enable   (en[0]),
    .i2s_mclk (mclk0),
    .i2s_ws   (ws0),
    .i2s_sd   (sd[0]),
    .m_data   (m_data0),
    .m_chan   (m_chan0),
    .m_valid  (m_valid0),
    .m_ready  (rdy[0]),
    .overflow (ovf0),
    .clr_ovf  (clr[0])
`ifdef I2S_RX_STATS_EN
    ,.drop_count (dc0)
`endif
  );

  i2s_rx_tdm #(
    .SLOT_BITS   (16),
    .SAMPLE_BITS (16),
    .CHANNELS    (8),
    .FIFO_DEPTH  (4)
  ) u_dut1 (
    .clk_in   (clk_in),
    .rstn     (rstn),
    .enable   (en[1]),
    .i2s_mclk (mclk1),
    .i2s_ws   (ws1),
    .i2s_sd   (sd[1]),
    .m_data   (m_data1),
    .m_chan   (m_chan1),
    .m_valid  (m_valid1),
    .m_ready  (rdy[1]),
    .overflow (ovf1),
    .clr_ovf  (clr[1])
`ifdef I2S_RX_STATS_EN
    ,.drop_count (dc1)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per instance a frame position, the slot words being sent,
  // and an ideal bounded queue of {chan, sample}.
  logic [31:0] words [2][8];
  logic [39:0] mq    [2][$];
  logic [39:0] got   [2][$];
  int          c_m   [2];
  bit          first_m [2];
  bit          ovf_m [2];
  int          dc_m  [2];
  bit          directed [2];

  function automatic int frame_len(input int id);
    return SB_P[id] * CH_P[id];
  endfunction

  task automatic refresh_words(input int id);
    for (int k = 0; k < 8; k++) begin
      if (!directed[id])  words[id][k] = $urandom;
      else if (id == 0)   words[id][k] = (k == 0) ? 32'hA5A5_5A5A : 32'h1234_5678;
      else                words[id][k] = 32'h1000 + k;
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      mq[id].delete();
      c_m[id] = 0; first_m[id] = 1'b1; ovf_m[id] = 1'b0; dc_m[id] = 0;
    end
  endtask

  function automatic logic model_sd(input int id);
    int fr, b, s, bp;
    logic [31:0] w;
    if (!en[id]) return 1'b0;
    fr = frame_len(id);
    b  = (c_m[id] + fr - 1) % fr;
    s  = b / SB_P[id];
    bp = SB_P[id] - 1 - (b % SB_P[id]);
    w  = words[id][s];
    return w[bp];
  endfunction

  task automatic model_edge(input int id);
    int fr, s;
    bit dropped;
    longint v;
    logic [39:0] e;
    fr = frame_len(id);
    dropped = 1'b0;
    if (rdy[id] && mq[id].size() > 0) void'(mq[id].pop_front());
    if (en[id] && (c_m[id] % SB_P[id] == 0) && !(first_m[id] && c_m[id] == 0)) begin
      s = (c_m[id] / SB_P[id] + CH_P[id] - 1) % CH_P[id];
      v = (longint'(words[id][s]) >> (SB_P[id] - SMP_P[id])) & ((64'd1 << SMP_P[id]) - 1);
      e = {8'(s), 32'(v)};
      if (mq[id].size() < DEP_P[id]) mq[id].push_back(e);
      else dropped = 1'b1;
    end
    if (dropped) begin
      ovf_m[id] = 1'b1;
      if (clr[id])                dc_m[id] = 1;
      else if (dc_m[id] < 65535)  dc_m[id]++;
    end else if (clr[id]) begin
      ovf_m[id] = 1'b0;
      dc_m[id]  = 0;
    end
    if (en[id]) begin
      if (c_m[id] == 0) begin
        first_m[id] = 1'b0;
        refresh_words(id);
      end
      c_m[id] = (c_m[id] + 1) % fr;
    end else begin
      c_m[id] = 0;
      first_m[id] = 1'b1;
    end
  endtask

  function automatic logic obs_valid(input int id);
    return (id == 0) ? m_valid0 : m_valid1;
  endfunction

  function automatic logic [39:0] obs_entry(input int id);
    if (id == 0) return {8'(m_chan0), 32'(m_data0)};
    return {8'(m_chan1), 32'(m_data1)};
  endfunction

  task automatic compare_outputs(input int id);
    logic exp_ws;
    int fr;
    fr = frame_len(id);
    exp_ws = en[id] && ((CH_P[id] == 2) ? (c_m[id] >= SB_P[id]) : (c_m[id] == fr - 1));
    check_val($sformatf("m_valid%0d", id), obs_valid(id), mq[id].size() > 0);
    if (mq[id].size() > 0) check_val($sformatf("m_entry%0d", id), obs_entry(id), mq[id][0]);
    check_val($sformatf("ws%0d", id), (id == 0) ? ws0 : ws1, exp_ws);
    check_val($sformatf("overflow%0d", id), (id == 0) ? ovf0 : ovf1, ovf_m[id]);
`ifdef I2S_RX_STATS_EN
    check_val($sformatf("drop_count%0d", id), (id == 0) ? dc0 : dc1, dc_m[id]);
`endif
  endtask

  // Called #1 after an active edge: drive sd, log pops, advance one edge, compare.
  task automatic tick();
    for (int id = 0; id < 2; id++) begin
      sd[id] = model_sd(id);
      if (obs_valid(id) && rdy[id]) got[id].push_back(obs_entry(id));
    end
    @(posedge clk_in);
    for (int id = 0; id < 2; id++) model_edge(id);
    #1;
    for (int id = 0; id < 2; id++) compare_outputs(id);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    for (int id = 0; id < 2; id++) begin
      en[id] = 1'b0; rdy[id] = 1'b0; clr[id] = 1'b0; sd[id] = 1'b0;
    end
    rstn = 1'b0;
    #2;
    model_reset();
    @(posedge clk_in);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit hit;
    directed[0] = 1'b1; directed[1] = 1'b1;
    refresh_words(0); refresh_words(1);
    for (int id = 0; id < 2; id++) begin
      en[id] = 1'b0; rdy[id] = 1'b0; clr[id] = 1'b0; sd[id] = 1'b0;
    end
    model_reset();
    #3;
    check_val("rst_m_valid0", m_valid0, 0);
    check_val("rst_m_data0", m_data0, 0);
    check_val("rst_m_chan0", m_chan0, 0);
    check_val("rst_overflow0", ovf0, 0);
    check_val("rst_ws0", ws0, 0);
    check_val("rst_m_valid1", m_valid1, 0);
    @(posedge clk_in); #1;
    rstn = 1'b1;
    #1;
    check_val("mclk_hi", mclk0, clk_in);
    @(negedge clk_in); #1;
    check_val("mclk_lo", mclk0, clk_in);
    @(posedge clk_in); #1;

    // Directed stereo frame and directed 8-slot TDM frame.
    en[0] = 1'b1; rdy[0] = 1'b1; en[1] = 1'b1; rdy[1] = 1'b1;
    got[0].delete(); got[1].delete();
    ticks(260);
    check_val("stereo_count", got[0].size() >= 2, 1);
    if (got[0].size() >= 2) begin
      check_val("stereo_first", got[0][0], {8'd0, 32'h00A5_A55A});
      check_val("stereo_second", got[0][1], {8'd1, 32'h0012_3456});
    end
    check_val("tdm_count", got[1].size() >= 8, 1);
    for (int k = 0; k < 8; k++)
      if (k < got[1].size()) check_val($sformatf("tdm_slot%0d", k), got[1][k], {8'(k), 32'h1000 + k});

    // Random words with a ready that mostly accepts, rare clears and enable toggles.
    directed[0] = 1'b0; directed[1] = 1'b0;
    for (int i = 0; i < 500; i++) begin
      for (int id = 0; id < 2; id++) begin
        rdy[id] = ($urandom_range(3) != 0);
        clr[id] = ($urandom_range(31) == 0);
        if ($urandom_range(99) == 0) en[id] = ~en[id];
      end
      tick();
    end
    // Random phase with ready mostly low to exercise drops and clears.
    en[0] = 1'b1; en[1] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int id = 0; id < 2; id++) begin
        rdy[id] = ($urandom_range(9) == 0);
        clr[id] = ($urandom_range(40) == 0);
      end
      tick();
    end

    // Three frames unread: four kept, two dropped, then drain in order.
    do_reset();
    en[0] = 1'b1;
    ticks(193);
    check_val("ovf_after_3frames", ovf0, 1);
`ifdef I2S_RX_STATS_EN
    check_val("drops_after_3frames", dc0, 2);
`endif
    en[0] = 1'b0; rdy[0] = 1'b1;
    got[0].delete();
    ticks(6);
    check_val("drained_count", got[0].size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got[0].size()) check_val($sformatf("drain_chan%0d", k), got[0][k][39:32], k % 2);

    // Two samples queued, overflow still set, then reset mid-frame.
    en[0] = 1'b1; rdy[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      hit = (mq[0].size() == 2);
    end
    check_val("two_queued_reached", hit, 1);
    ticks(5);
    check_val("pre_reset_ovf", ovf0, 1);
    rstn = 1'b0;
    #1;
    check_val("async_rst_m_valid", m_valid0, 0);
    check_val("async_rst_overflow", ovf0, 0);
    check_val("async_rst_m_data", m_data0, 0);
    model_reset();
    @(posedge clk_in); #1;
    rstn = 1'b1;
    rdy[0] = 1'b1;
    got[0].delete();
    ticks(33);
    check_val("no_stale_after_reset", got[0].size(), 0);
    ticks(10);

    // Full FIFO, ready high exactly on the push edge: no drop.
    do_reset();
    en[0] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick();
      hit = (mq[0].size() == 4);
    end
    check_val("fifo_filled", hit, 1);
    n = 0;
    while ((c_m[0] % 32) != 0 && n < 64) begin tick(); n++; end
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    check_val("push_pop_full_ovf", ovf0, 0);
    check_val("push_pop_full_valid", m_valid0, 1);
    // Next push while full and a same-cycle clear: the drop wins.
    n = 0;
    while ((c_m[0] % 32) != 0 && n < 64) begin tick(); n++; end
    clr[0] = 1'b1;
    tick();
    check_val("drop_beats_clear", ovf0, 1);
`ifdef I2S_RX_STATS_EN
    check_val("drop_with_clear_count", dc0, 1);
`endif
    tick();
    clr[0] = 1'b0;
    check_val("clear_ovf", ovf0, 0);

    // Enable dropped at c=20 and raised again: first sample is chan 0 at c=SLOT_BITS.
    do_reset();
    en[0] = 1'b1; rdy[0] = 1'b1;
    ticks(70);
    n = 0;
    while (c_m[0] != 20 && n < 128) begin tick(); n++; end
    en[0] = 1'b0;
    ticks(3);
    en[0] = 1'b1;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 100) begin
      tick();
      n++;
      hit = m_valid0;
    end
    check_val("restart_first_valid_cycle", n, 33);
    check_val("restart_first_chan", m_chan0, 0);
    ticks(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
